// File: rtl/comparador_sched.sv
`default_nettype none
// ============================================================================
// Module   : comparador_sched
// Purpose  : Time-multiplexes one external comparator across four 5-bit
//            channels. Each channel takes two cycles (SETUP presents the
//            operands, SAMPLE captures the result). Every sampled result feeds
//            a per-channel debounce counter that toggles the channel alarm
//            after DEB consecutive results that disagree with it.
// Ports    : clk, rst_n          clock, asynchronous active-low reset
//            run                 scan continuously while high
//            umbral              alarm threshold, latched at scan start
//            d0..d3              channel values
//            cmp_l               external comparator result (cmp_d >= cmp_a)
//            cmp_d, cmp_a        comparator operands
//            ch                  channel owning the comparator
//            alarm, any_alarm    debounced alarms and their OR
//            busy                high outside IDLE
//            scan_done           one-cycle pulse after channel 3 is sampled
// Config   : COMPARADOR_SCHED_HYST_EN -- when defined, alarmed channels are
//            compared against umbral_q - HYST (saturating at 0).
// Revision : 1.0  initial release
// ============================================================================
module comparador_sched #(
   parameter int DEB  = 3,
   parameter int HYST = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic [4:0] umbral,
   input  logic [4:0] d0,
   input  logic [4:0] d1,
   input  logic [4:0] d2,
   input  logic [4:0] d3,
   input  logic       cmp_l,
   output logic [4:0] cmp_d,
   output logic [4:0] cmp_a,
   output logic [1:0] ch,
   output logic [3:0] alarm,
   output logic       any_alarm,
   output logic       busy,
   output logic       scan_done
);

`ifdef COMPARADOR_SCHED_HYST_EN
   localparam bit HYST_ON = 1'b1;
`else
   localparam bit HYST_ON = 1'b0;
`endif

   localparam logic [2:0] DEB_C  = 3'(DEB);
   localparam logic [4:0] HYST_C = 5'(HYST);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      SAMPLE = 2'd2
   } state_t;

   state_t          state, state_nx;
   logic [1:0]      ch_nx;
   logic [4:0]      cmp_d_nx, cmp_a_nx;
   logic [4:0]      umbral_q, umbral_q_nx;
   logic [3:0]      alarm_nx;
   logic            scan_done_nx;
   logic [3:0][2:0] cnt, cnt_nx;

   logic [4:0]      d_sel;
   logic [4:0]      thr_hyst;
   logic [4:0]      thr_eff;
   logic [2:0]      cnt_inc;

   always_comb begin
      case (ch)
         2'd0:    d_sel = d0;
         2'd1:    d_sel = d1;
         2'd2:    d_sel = d2;
         default: d_sel = d3;
      endcase
   end

   // Threshold for the channel being set up; the alarmed-channel reduction
   // folds away entirely when hysteresis is not built in.
   assign thr_hyst = (umbral_q > HYST_C) ? (umbral_q - HYST_C) : 5'd0;
   assign thr_eff  = (HYST_ON && alarm[ch]) ? thr_hyst : umbral_q;

   // Saturating increment of the current channel's disagreement counter.
   assign cnt_inc  = (cnt[ch] == 3'd7) ? 3'd7 : (cnt[ch] + 3'd1);

   always_comb begin
      state_nx     = state;
      ch_nx        = ch;
      cmp_d_nx     = cmp_d;
      cmp_a_nx     = cmp_a;
      umbral_q_nx  = umbral_q;
      alarm_nx     = alarm;
      cnt_nx       = cnt;
      scan_done_nx = 1'b0;

      case (state)
         IDLE: begin
            if (run) begin
               state_nx    = SETUP;
               ch_nx       = 2'd0;
               umbral_q_nx = umbral;
            end
         end

         SETUP: begin
            cmp_d_nx = d_sel;
            cmp_a_nx = thr_eff;
            state_nx = SAMPLE;
         end

         SAMPLE: begin
            if (cmp_l == alarm[ch]) begin
               cnt_nx[ch] = 3'd0;
            end else if (cnt_inc >= DEB_C) begin
               alarm_nx[ch] = ~alarm[ch];
               cnt_nx[ch]   = 3'd0;
            end else begin
               cnt_nx[ch] = cnt_inc;
            end

            if (ch != 2'd3) begin
               ch_nx    = ch + 2'd1;
               state_nx = SETUP;
            end else begin
               ch_nx        = 2'd0;
               scan_done_nx = 1'b1;
               if (run) begin
                  state_nx    = SETUP;
                  umbral_q_nx = umbral;
               end else begin
                  state_nx = IDLE;
               end
            end
         end

         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ch        <= 2'd0;
         cmp_d     <= 5'd0;
         cmp_a     <= 5'd0;
         umbral_q  <= 5'd0;
         alarm     <= 4'd0;
         any_alarm <= 1'b0;
         busy      <= 1'b0;
         scan_done <= 1'b0;
         cnt       <= '0;
      end else begin
         state     <= state_nx;
         ch        <= ch_nx;
         cmp_d     <= cmp_d_nx;
         cmp_a     <= cmp_a_nx;
         umbral_q  <= umbral_q_nx;
         alarm     <= alarm_nx;
         any_alarm <= |alarm_nx;
         busy      <= (state_nx != IDLE);
         scan_done <= scan_done_nx;
         cnt       <= cnt_nx;
      end
   end

endmodule
`default_nettype wire

// File: doc/comparador_sched.md
COMPARADOR_SCHED -- requirements
Module: comparador_sched

Interface
- REQ-001: Parameter DEB, default 3, range 1..7: consecutive identical comparator results required to change a channel alarm.
- REQ-002: Parameter HYST, default 2, range 0..31: threshold reduction applied to alarmed channels (only with COMPARADOR_SCHED_HYST_EN).
- REQ-003: One clock, clk; reset is asynchronous and active-low, rst_n.
- REQ-004: clk  input  1  rising-edge system clock.
- REQ-005: rst_n  input  1  asynchronous active-low reset.
- REQ-006: run  input  1  high = scan continuously; low = finish current scan, then idle.
- REQ-007: umbral  input  5  unsigned alarm threshold.
- REQ-008: d0, d1, d2, d3  input  5 each  unsigned channel values.
- REQ-009: cmp_l  input  1  result from the shared external comparator; 1 when cmp_d >= cmp_a.
- REQ-010: cmp_d  output  5  value presented to the comparator D input.
- REQ-011: cmp_a  output  5  threshold presented to the comparator A input.
- REQ-012: ch  output  2  channel currently owning the comparator.
- REQ-013: alarm  output  4  per-channel debounced alarm, bit i = channel i.
- REQ-014: any_alarm  output  1  OR of alarm.
- REQ-015: busy  output  1  high in any state other than IDLE.
- REQ-016: scan_done  output  1  one-cycle pulse at the end of each full 4-channel scan.

Function
- REQ-017: The FSM SHALL have states IDLE, SETUP, SAMPLE, with registered outputs.
- REQ-018: IDLE -> SETUP when run=1; ch<=0; umbral latched into umbral_q.
- REQ-019: In SETUP, cmp_d<=d[ch] and cmp_a<=effective threshold; next state SAMPLE.
- REQ-020: In SAMPLE, cmp_l is captured; the FSM goes to SETUP with ch+1 if ch<3.
- REQ-021: In SAMPLE with ch=3, scan_done pulses next cycle and ch<=0. If run=1, the FSM goes to SETUP and re-latches umbral; otherwise it goes to IDLE.
- REQ-022: One channel takes 2 cycles; a full scan takes 8 cycles; a start-to-first-scan_done latency is 9 cycles from the run rising edge sampled in IDLE.
- REQ-023: umbral changes mid-scan SHALL NOT affect the scan in progress.
- REQ-024: Each channel SHALL have a 3-bit saturating counter cnt[i] of consecutive results differing from alarm[i]. A result equal to alarm[i] clears cnt[i]; otherwise cnt[i] increments.
- REQ-025: When cnt[i] reaches DEB, alarm[i] SHALL toggle and cnt[i] SHALL clear in the same cycle.
- REQ-026: alarm and any_alarm SHALL update on the clock edge ending SAMPLE. Channels not sampled SHALL hold their state.
- REQ-027: run dropping mid-scan SHALL NOT abort the scan; alarm and cnt SHALL persist across IDLE.
- REQ-028: cmp_d and cmp_a SHALL hold their last values in IDLE.

Reset
- REQ-029: rst_n low SHALL immediately force state=IDLE, ch=0, cmp_d=0, cmp_a=0, alarm=0, any_alarm=0, busy=0, scan_done=0, all cnt=0, and umbral_q=0.
- REQ-030: Reset mid-scan SHALL discard the partial scan; the first scan after release starts at channel 0.

Configuration
- REQ-031: Macro COMPARADOR_SCHED_HYST_EN.
  - Defined: the effective threshold is umbral_q minus HYST (saturating at 0) for a channel whose alarm is 1, and umbral_q for a channel whose alarm is 0.
  - Undefined: the effective threshold is always umbral_q, and HYST is ignored.

Verification
- REQ-032: Reset then run=1, umbral=25, d0..d3=24,25,30,0, DEB=3 -> alarm=4'b0110 after the 3rd scan_done, not before.
- REQ-033: Continuous run -> scan_done pulses every 8 cycles; ch sequences 0,0,1,1,2,2,3,3.
- REQ-034: With alarm[1]=1, set d1=20 for 2 scans then 26 -> alarm[1] stays 1 (counter cleared).
- REQ-035: HYST_EN defined, HYST=2, umbral=25, alarm[2]=1, d2=24 -> cmp_a=23 on channel 2 and alarm[2] stays 1. Undefined -> alarm[2] clears after 3 scans.
- REQ-036: Drop run at ch=1 -> scan completes through ch=3, scan_done pulses, and busy=0 the next cycle.
- REQ-037: Assert rst_n=0 mid-scan with alarm=4'b1111 -> all outputs 0 asynchronously; after release with run=1, the scan restarts at ch=0.
